// File: rtl/cp0_pkg.sv
// Shared cp0 definitions: register indices, ExcCodes and Status/Cause bit positions.
// Pure constants and a Cause packing helper; no timing or flow control of its own.
package cp0_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_SYSCALL = 5'b01000;
  localparam logic [4:0] EXC_BREAK   = 5'b01001;
  localparam logic [4:0] EXC_TEQ     = 5'b01101;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_IM7   = 15;
  localparam int CAUSE_IP7    = 15;
  localparam int STATUS_SHIFT = 5;

  // Cause layout: IP7 at 15, software IP at [9:8], ExcCode at [6:2], everything else reads 0.
  function automatic logic [31:0] pack_cause(input logic ip7, input logic [1:0] ip_sw,
                                             input logic [4:0] exc_code);
    pack_cause = {16'b0, ip7, 5'b0, ip_sw, 1'b0, exc_code, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Decoder-to-cp0 request/response bundle: requests flow master->slave, read data and vectors back.
// Purely combinational wiring; pipeline stall is carried by ena rather than a handshake.
interface cp0_if;
  logic        ena;
  logic        mfc0;
  logic        mtc0;
  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic [31:0] rdata;
  logic [31:0] exc_addr;
  logic [31:0] status;
  logic        int_pending;

  modport master (
    output ena, mfc0, mtc0, exception, eret, cause, addr, wdata, pc,
    input  rdata, exc_addr, status, int_pending
  );

  modport slave (
    input  ena, mfc0, mtc0, exception, eret, cause, addr, wdata, pc,
    output rdata, exc_addr, status, int_pending
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky IP7; writes land on the next edge, Count free-runs every clock.
// No backpressure: the caller qualifies write strobes with ena, the counter ignores stalls.
module cp0_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_count_we,
  input  logic        i_compare_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_count,
  output logic [31:0] o_compare,
  output logic        o_ip7
);

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ip7;
  logic        w_match;

  assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_ip7     <= 1'b0;
    end else begin
      r_count <= i_count_we ? i_wdata : r_count + 32'd1;
      if (i_compare_we) begin
        r_compare <= i_wdata;
      end
      // Writing Compare acknowledges the interrupt and beats a coincident match.
      if (i_compare_we) begin
        r_ip7 <= 1'b0;
      end else if (w_match) begin
        r_ip7 <= 1'b1;
      end
    end
  end

  assign o_count   = r_count;
  assign o_compare = r_compare;
  assign o_ip7     = r_ip7;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0: Status/Cause/EPC, exception/eret sequencing, timer; reads and exc_addr are same-cycle.
// Updates land on the next edge and only when ena=1; ena=0 holds architectural state (Count runs on).
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_000F
) (
  input  logic clk,
  input  logic rst_n,
  cp0_if.slave cp0
);

  logic [31:0] r_status;
  logic [31:0] r_epc;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exc_code;

  logic        w_eret;
  logic        w_exc;
  logic        w_wr;
  logic [31:0] w_count;
  logic [31:0] w_compare;
  logic        w_ip7;
  logic [31:0] w_cause;
  logic [31:0] w_rdata;
  logic [31:0] w_exc_addr;

  // Priority eret > exception > mtc0; eret arrives with exception raised, so both are excluded.
  assign w_eret = cp0.ena & cp0.eret;
  assign w_exc  = cp0.ena & cp0.exception & ~cp0.eret;
  assign w_wr   = cp0.ena & cp0.mtc0 & ~cp0.exception & ~cp0.eret;

  cp0_timer u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_count_we   (w_wr && (cp0.addr == CP0_COUNT)),
    .i_compare_we (w_wr && (cp0.addr == CP0_COMPARE)),
    .i_wdata      (cp0.wdata),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_ip7        (w_ip7)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status   <= STATUS_RST;
      r_epc      <= 32'd0;
      r_ip_sw    <= 2'b00;
      r_exc_code <= 5'd0;
    end else if (w_eret) begin
      r_status <= r_status >> STATUS_SHIFT;
    end else if (w_exc) begin
      r_status   <= r_status << STATUS_SHIFT;
      r_epc      <= cp0.pc;
      r_exc_code <= cp0.cause;
    end else if (w_wr) begin
      case (cp0.addr)
        CP0_STATUS: r_status <= cp0.wdata;
        CP0_CAUSE:  r_ip_sw  <= cp0.wdata[9:8];
        CP0_EPC:    r_epc    <= cp0.wdata;
        default:    ;
      endcase
    end
  end

  assign w_cause = pack_cause(w_ip7, r_ip_sw, r_exc_code);

  always_comb begin
    w_rdata = 32'd0;
    if (cp0.mfc0) begin
      case (cp0.addr)
        CP0_COUNT:   w_rdata = w_count;
        CP0_COMPARE: w_rdata = w_compare;
        CP0_STATUS:  w_rdata = r_status;
        CP0_CAUSE:   w_rdata = w_cause;
        CP0_EPC:     w_rdata = r_epc;
        default:     w_rdata = 32'd0;
      endcase
    end
  end

  // Ungated by ena: the control unit decides whether to take the redirect.
  always_comb begin
    w_exc_addr = 32'd0;
    if (cp0.eret) begin
      w_exc_addr = r_epc;
    end else if (cp0.exception) begin
      w_exc_addr = EXC_VECTOR;
    end
  end

  assign cp0.rdata       = w_rdata;
  assign cp0.exc_addr    = w_exc_addr;
  assign cp0.status      = r_status;
  assign cp0.int_pending = w_ip7 & r_status[STATUS_IM7] & r_status[STATUS_IE];

endmodule
